pipeline_hazard_ctrl: RTL and testbench

//   Central stall/flush sequencer for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 17 +
 rtl/pipeline_hazard_ctrl_if.sv | 40 ++++
 rtl/pipeline_hazard_ctrl_load_use_detect.sv | 18 +
 rtl/pipeline_hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared state encodings and types for the pipeline stall/flush sequencer.
// Imported by the interface, the comparator and the top-level FSM.
package pipeline_hazard_ctrl_pkg;

    localparam int CTRL_STATE_WIDTH = 2;

    typedef logic [CTRL_STATE_WIDTH-1:0] ctrl_state_t;

    localparam ctrl_state_t CTRL_RUN      = 2'd0;
    localparam ctrl_state_t CTRL_MEM_WAIT = 2'd1;
    localparam ctrl_state_t CTRL_FLUSH    = 2'd2;

    localparam int REG_ADDR_WIDTH = 5;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline status inputs and stall/flush controls around the sequencer.
// The pipeline side drives through master; the sequencer attaches as slave.
interface pipeline_hazard_ctrl_if;
    import pipeline_hazard_ctrl_pkg::*;

    logic      dec_valid;
    reg_addr_t dec_rs1;
    reg_addr_t dec_rs2;
    logic      alu_valid;
    logic      alu_is_load;
    reg_addr_t alu_rd;
    logic      alu_change_pc;
    logic      alu_mem_req;
    logic      mem_ack;
    logic      trap_req;

    logic      stall_if;
    logic      stall_id;
    logic      force_stall_alu;
    logic      bubble_ex;
    logic      flush_if;
    logic      flush_id;
    logic      flush_alu;
    logic      mem_timeout_exc;

    modport master (
        output dec_valid, dec_rs1, dec_rs2, alu_valid, alu_is_load, alu_rd,
               alu_change_pc, alu_mem_req, mem_ack, trap_req,
        input  stall_if, stall_id, force_stall_alu, bubble_ex,
               flush_if, flush_id, flush_alu, mem_timeout_exc
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, alu_valid, alu_is_load, alu_rd,
               alu_change_pc, alu_mem_req, mem_ack, trap_req,
        output stall_if, stall_id, force_stall_alu, bubble_ex,
               flush_if, flush_id, flush_alu, mem_timeout_exc
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Pure load-use comparator: a load in EX whose destination is read by the
// instruction in ID. Register x0 is hard-wired zero and never hazards.
module load_use_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic      dec_valid,
    input  reg_addr_t dec_rs1,
    input  reg_addr_t dec_rs2,
    input  logic      alu_valid,
    input  logic      alu_is_load,
    input  reg_addr_t alu_rd,
    output logic      hazard
);

    assign hazard = dec_valid && alu_valid && alu_is_load && (alu_rd != 5'd0) &&
                    ((alu_rd == dec_rs1) || (alu_rd == dec_rs2));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: load-use stalls, data
// memory wait with timeout, and multi-cycle front-end flush after redirects/traps.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    pipeline_hazard_ctrl_if.slave   hz
);

    localparam int             CW           = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [CW-1:0]  CNT_ZERO     = {CW{1'b0}};
    localparam logic [CW-1:0]  CNT_ONE      = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  CNT_MAX      = {CW{1'b1}};
    localparam logic [CW-1:0]  TIMEOUT_LAST = CW'(MEM_TIMEOUT - 1);
    localparam logic [CW-1:0]  FLUSH_LOAD   = CW'(FLUSH_CYCLES - 1);
    localparam ctrl_state_t    REDIRECT_ST  = (FLUSH_CYCLES > 1) ? CTRL_FLUSH : CTRL_RUN;

    ctrl_state_t   state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic [CW-1:0] flush_cnt_q, flush_cnt_d;

    logic hazard_s;
    logic stall_s, force_s, bubble_s, flush_fe_s, flush_alu_s, timeout_s;

    load_use_detect u_load_use_detect (
        .dec_valid   (hz.dec_valid),
        .dec_rs1     (hz.dec_rs1),
        .dec_rs2     (hz.dec_rs2),
        .alu_valid   (hz.alu_valid),
        .alu_is_load (hz.alu_is_load),
        .alu_rd      (hz.alu_rd),
        .hazard      (hazard_s)
    );

    // Next-state, counter and output decode; trap_req overrides every state.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        flush_cnt_d = flush_cnt_q;
        stall_s     = 1'b0;
        force_s     = 1'b0;
        bubble_s    = 1'b0;
        flush_fe_s  = 1'b0;
        flush_alu_s = 1'b0;
        timeout_s   = 1'b0;

        if (hz.trap_req) begin
            flush_fe_s  = 1'b1;
            flush_alu_s = 1'b1;
            wait_cnt_d  = CNT_ZERO;
            flush_cnt_d = FLUSH_LOAD;
            state_d     = REDIRECT_ST;
        end else begin
            case (state_q)
                CTRL_RUN: begin
                    if (hz.alu_change_pc && hz.alu_valid) begin
                        flush_fe_s  = 1'b1;
                        flush_cnt_d = FLUSH_LOAD;
                        state_d     = REDIRECT_ST;
                    end else if (hz.alu_mem_req && !hz.mem_ack) begin
                        wait_cnt_d = CNT_ONE;
                        state_d    = CTRL_MEM_WAIT;
                    end else if (hazard_s) begin
                        stall_s  = 1'b1;
                        bubble_s = 1'b1;
                    end else begin
                        state_d = CTRL_RUN;
                    end
                end
                CTRL_MEM_WAIT: begin
                    // EX is frozen here, so a pending redirect is re-evaluated after release.
                    if (hz.mem_ack) begin
                        wait_cnt_d = CNT_ZERO;
                        state_d    = CTRL_RUN;
                    end else if (wait_cnt_q >= TIMEOUT_LAST) begin
                        timeout_s   = 1'b1;
                        flush_fe_s  = 1'b1;
                        flush_alu_s = 1'b1;
                        wait_cnt_d  = CNT_ZERO;
                        flush_cnt_d = FLUSH_LOAD;
                        state_d     = REDIRECT_ST;
                    end else begin
                        stall_s    = 1'b1;
                        force_s    = 1'b1;
                        wait_cnt_d = (wait_cnt_q == CNT_MAX) ? CNT_MAX : wait_cnt_q + CNT_ONE;
                    end
                end
                CTRL_FLUSH: begin
                    flush_fe_s = 1'b1;
                    if (flush_cnt_q <= CNT_ONE) begin
                        flush_cnt_d = CNT_ZERO;
                        state_d     = CTRL_RUN;
                    end else begin
                        flush_cnt_d = flush_cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d     = CTRL_RUN;
                    wait_cnt_d  = CNT_ZERO;
                    flush_cnt_d = CNT_ZERO;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= CTRL_RUN;
            wait_cnt_q  <= CNT_ZERO;
            flush_cnt_q <= CNT_ZERO;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Gated by rstn so every control is quiet while reset is held.
    assign hz.stall_if        = rstn & stall_s;
    assign hz.stall_id        = rstn & stall_s;
    assign hz.force_stall_alu = rstn & force_s;
    assign hz.bubble_ex       = rstn & bubble_s;
    assign hz.flush_if        = rstn & flush_fe_s;
    assign hz.flush_id        = rstn & flush_fe_s;
    assign hz.flush_alu       = rstn & flush_alu_s;
    assign hz.mem_timeout_exc = rstn & timeout_s;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MEM_TIMEOUT=16, FLUSH_CYCLES=2).
// Output vector order: stall_if stall_id force_stall_alu bubble_ex flush_if flush_id flush_alu mem_timeout_exc.
module tb_pipeline_hazard_ctrl;

    logic clk;
    logic rstn;
    int   errors;
    int   checks;

    pipeline_hazard_ctrl_if hz_if ();

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT  (16),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .hz   (hz_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [7:0] O_NONE    = 8'b0000_0000;
    localparam logic [7:0] O_LU      = 8'b1101_0000;
    localparam logic [7:0] O_MEM     = 8'b1110_0000;
    localparam logic [7:0] O_FLUSH   = 8'b0000_1100;
    localparam logic [7:0] O_TRAP    = 8'b0000_1110;
    localparam logic [7:0] O_TIMEOUT = 8'b0000_1111;

    task automatic check(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {hz_if.stall_if, hz_if.stall_id, hz_if.force_stall_alu, hz_if.bubble_ex,
               hz_if.flush_if, hz_if.flush_id, hz_if.flush_alu, hz_if.mem_timeout_exc};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz_if.dec_valid     = 1'b0;
        hz_if.dec_rs1       = 5'd0;
        hz_if.dec_rs2       = 5'd0;
        hz_if.alu_valid     = 1'b0;
        hz_if.alu_is_load   = 1'b0;
        hz_if.alu_rd        = 5'd0;
        hz_if.alu_change_pc = 1'b0;
        hz_if.alu_mem_req   = 1'b0;
        hz_if.mem_ack       = 1'b0;
        hz_if.trap_req      = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        hz_if.dec_valid   = 1'b1;
        hz_if.dec_rs1     = rs1;
        hz_if.dec_rs2     = rs2;
        hz_if.alu_valid   = 1'b1;
        hz_if.alu_is_load = 1'b1;
        hz_if.alu_rd      = rd;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rstn   = 1'b0;
        idle();
        #4;
        check("reset_idle", O_NONE);
        set_lu(5'd5, 5'd5, 5'd1);
        #1;
        check("reset_hazard_masked", O_NONE);

        tick();
        idle();
        rstn = 1'b1;
        #4;
        check("run_idle", O_NONE);

        // lw x5 in EX, add x6,x5,x1 in ID
        tick(); set_lu(5'd5, 5'd5, 5'd1); #4;
        check("lu_rs1", O_LU);
        tick(); hz_if.alu_is_load = 1'b0; #4;
        check("lu_released", O_NONE);
        tick(); set_lu(5'd7, 5'd3, 5'd7); #4;
        check("lu_rs2", O_LU);
        tick(); set_lu(5'd0, 5'd0, 5'd0); #4;
        check("lu_x0", O_NONE);
        tick(); set_lu(5'd9, 5'd9, 5'd2); hz_if.dec_valid = 1'b0; #4;
        check("lu_dec_invalid", O_NONE);

        // memory wait: three stalled cycles, ack drops the stall
        tick(); idle(); hz_if.alu_mem_req = 1'b1; #4;
        check("mw_enter", O_NONE);
        for (int i = 0; i < 3; i++) begin
            tick(); #4;
            check("mw_stall", O_MEM);
        end
        tick(); hz_if.mem_ack = 1'b1; #4;
        check("mw_ack", O_NONE);
        tick(); idle(); set_lu(5'd4, 5'd4, 5'd1); #4;
        check("mw_back_run", O_LU);

        // request acked in the same cycle stays in RUN
        tick(); idle(); hz_if.alu_mem_req = 1'b1; hz_if.mem_ack = 1'b1; #4;
        check("mw_same_ack", O_NONE);
        tick(); idle(); set_lu(5'd4, 5'd1, 5'd4); #4;
        check("mw_same_ack_run", O_LU);

        // change_pc without alu_valid does nothing
        tick(); idle(); hz_if.alu_change_pc = 1'b1; #4;
        check("br_invalid", O_NONE);

        // branch: two flush cycles, load-use ignored in FLUSH, RUN on third
        tick(); idle(); hz_if.alu_change_pc = 1'b1; hz_if.alu_valid = 1'b1; #4;
        check("br_cycle0", O_FLUSH);
        tick(); idle(); set_lu(5'd6, 5'd6, 5'd1); #4;
        check("br_cycle1", O_FLUSH);
        tick(); #4;
        check("br_run", O_LU);

        // timeout: 14 stalled cycles (redirect ignored), pulse on the 15th, one more flush
        tick(); idle(); hz_if.alu_mem_req = 1'b1; #4;
        check("to_enter", O_NONE);
        for (int i = 1; i <= 14; i++) begin
            tick();
            hz_if.alu_change_pc = (i == 7);
            hz_if.alu_valid     = (i == 7);
            #4;
            check("to_stall", O_MEM);
        end
        tick(); #4;
        check("to_pulse", O_TIMEOUT);
        tick(); idle(); #4;
        check("to_flush", O_FLUSH);
        tick(); #4;
        check("to_run", O_NONE);

        // trap in MEM_WAIT with a simultaneous redirect
        tick(); idle(); hz_if.alu_mem_req = 1'b1; #4;
        check("tr_enter", O_NONE);
        tick(); #4;
        check("tr_wait", O_MEM);
        tick(); hz_if.trap_req = 1'b1; hz_if.alu_change_pc = 1'b1; hz_if.alu_valid = 1'b1; #4;
        check("tr_trap", O_TRAP);
        tick(); idle(); #4;
        check("tr_flush", O_FLUSH);
        tick(); set_lu(5'd8, 5'd8, 5'd8); #4;
        check("tr_run", O_LU);

        // trap inside FLUSH reloads the flush counter
        tick(); idle(); hz_if.alu_change_pc = 1'b1; hz_if.alu_valid = 1'b1; #4;
        check("tf_branch", O_FLUSH);
        tick(); idle(); hz_if.trap_req = 1'b1; #4;
        check("tf_trap", O_TRAP);
        tick(); idle(); hz_if.alu_change_pc = 1'b1; hz_if.alu_valid = 1'b1; #4;
        check("tf_reloaded", O_FLUSH);
        tick(); idle(); #4;
        check("tf_run", O_NONE);

        // reset asserted mid-FLUSH
        tick(); hz_if.alu_change_pc = 1'b1; hz_if.alu_valid = 1'b1; #4;
        check("rs_branch", O_FLUSH);
        tick(); idle(); #2;
        check("rs_in_flush", O_FLUSH);
        rstn = 1'b0;
        #1;
        check("rs_asserted", O_NONE);
        tick(); rstn = 1'b1; #4;
        check("rs_released", O_NONE);
        tick(); set_lu(5'd3, 5'd3, 5'd0); #4;
        check("rs_run", O_LU);

        tick(); idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
